mod4_sequence_monitor: RTL and testbench

Checker stage that sits directly downstream of the mod-4 synchronous counter and consumes its 2-bit count output every clock. It verifies that the count follows 0->1->2->3->0, locks onto a valid sequence, and flags sequence errors. It also counts completed wraps (3->0) and errors for status and debug.

---
 rtl/mod4_mon_pkg.sv | 18 +
 rtl/mod4_sequence_monitor_sat_counter.sv | 34 +++
 rtl/mod4_sequence_monitor.sv | 116 +++++++++++
 tb/tb_mod4_sequence_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod4_mon_pkg.sv
// Shared types and helpers for the mod-4 sequence monitor.
// The state enum encoding is visible on the state output, so it must not change.
package mod4_mon_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } mon_state_e;

    localparam int MOD = 4;

    function automatic logic [1:0] next_cnt(input logic [1:0] x);
        return 2'((int'(x) + 1) % MOD);
    endfunction

endpackage

// File: rtl/mod4_sequence_monitor_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/mod4_sequence_monitor.sv
// Checks that an upstream mod-4 count advances 0->1->2->3->0, locks onto it,
// and reports wraps and sequence errors through registered pulses and counters.
module mod4_sequence_monitor
    import mod4_mon_pkg::*;
#(
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4,
    parameter int LOCK_CNT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        cnt_in,
    input  logic              clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic              seq_err,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        state
);

    mon_state_e state_q, state_d;
    logic [1:0] prev_q, prev_d;
    logic [2:0] run_q, run_d;
    logic       wrap_pulse_q, wrap_pulse_d;
    logic       seq_err_q, seq_err_d;
    logic       locked_q, locked_d;
    logic       match;

    assign match = (cnt_in == next_cnt(prev_q));

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        wrap_pulse_d = 1'b0;
        seq_err_d    = 1'b0;
        if (en) begin
            prev_d = cnt_in;
            case (state_q)
                ST_UNSYNC: begin
                    state_d = ST_ACQUIRE;
                    run_d   = '0;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        run_d = run_q + 3'd1;
                        if (run_d == 3'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        wrap_pulse_d = (prev_q == 2'd3) && (cnt_in == 2'd0);
                    end else begin
                        // A held value also lands here, since it is not prev+1.
                        seq_err_d = 1'b1;
                        state_d   = ST_ACQUIRE;
                        run_d     = '0;
                    end
                end
                default: begin
                    state_d = ST_UNSYNC;
                    run_d   = '0;
                end
            endcase
        end else if (state_q == ST_ILLEGAL) begin
            state_d = ST_UNSYNC;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNSYNC;
            prev_q       <= '0;
            run_q        <= '0;
            wrap_pulse_q <= 1'b0;
            seq_err_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            wrap_pulse_q <= wrap_pulse_d;
            seq_err_q    <= seq_err_d;
            locked_q     <= locked_d;
        end
    end

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wrap_pulse_d),
        .q   (wrap_count)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (seq_err_d),
        .q   (err_count)
    );

    assign locked     = locked_q;
    assign wrap_pulse = wrap_pulse_q;
    assign seq_err    = seq_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mod4_sequence_monitor.sv
// Directed scenarios plus a randomized run, compared every cycle against a
// behavioural model of the monitor; small error counter to exercise saturation.
module tb_mod4_sequence_monitor;

    localparam int WRAP_W   = 8;
    localparam int ERR_W    = 2;
    localparam int LOCK_CNT = 2;
    localparam int WMAX     = (1 << WRAP_W) - 1;
    localparam int EMAX     = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [1:0]        cnt_in = 2'd0;
    logic              clr = 1'b0;
    logic              locked;
    logic              wrap_pulse;
    logic              seq_err;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;
    logic [1:0]        state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 = not synced, 1 = acquiring, 2 = locked.
    int m_mode = 0, m_prev = 0, m_run = 0, m_wraps = 0, m_errs = 0;
    int m_wp = 0, m_se = 0;

    mod4_sequence_monitor #(
        .WRAP_W   (WRAP_W),
        .ERR_W    (ERR_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .seq_err    (seq_err),
        .wrap_count (wrap_count),
        .err_count  (err_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int c;
        int is_next;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0; m_errs = 0;
                m_wp = 0; m_se = 0;
            end else begin
                m_wp = 0;
                m_se = 0;
                if (en) begin
                    c = int'(cnt_in);
                    is_next = (c == (m_prev + 1) % 4);
                    if (m_mode == 0) begin
                        m_mode = 1;
                        m_run = 0;
                    end else if (m_mode == 1) begin
                        if (is_next != 0) begin
                            m_run++;
                            if (m_run == LOCK_CNT) m_mode = 2;
                        end else begin
                            m_run = 0;
                        end
                    end else begin
                        if (is_next != 0) begin
                            if (m_prev == 3 && c == 0) begin
                                m_wp = 1;
                                if (m_wraps < WMAX) m_wraps++;
                            end
                        end else begin
                            m_se = 1;
                            if (m_errs < EMAX) m_errs++;
                            m_mode = 1;
                            m_run = 0;
                        end
                    end
                    m_prev = c;
                end
                if (clr) begin
                    m_wraps = 0;
                    m_errs = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("state", int'(state), m_mode);
            chk("locked", int'(locked), (m_mode == 2) ? 1 : 0);
            chk("wrap_pulse", int'(wrap_pulse), m_wp);
            chk("seq_err", int'(seq_err), m_se);
            chk("wrap_count", int'(wrap_count), m_wraps);
            chk("err_count", int'(err_count), m_errs);
        end
    end

    task automatic step(input bit e, input int c, input bit k);
        @(negedge clk);
        en = e;
        cnt_in = 2'(c);
        clr = k;
        @(posedge clk);
        #1;
    endtask

    function automatic int nxt();
        return (m_prev + 1) % 4;
    endfunction

    task automatic relock();
        step(1'b1, nxt(), 1'b0);
        step(1'b1, nxt(), 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_outputs", int'({locked, wrap_pulse, seq_err}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Lock and wrap on a clean counter stream.
        step(1'b1, 0, 1'b0);
        chk("lock_first_state", int'(state), 1);
        step(1'b1, 1, 1'b0);
        chk("lock_not_yet", int'(locked), 0);
        step(1'b1, 2, 1'b0);
        chk("lock_on_2", int'(locked), 1);
        step(1'b1, 3, 1'b0);
        step(1'b1, 0, 1'b0);
        chk("wrap_pulse_hi", int'(wrap_pulse), 1);
        chk("wrap_count_1", int'(wrap_count), 1);
        step(1'b1, 1, 1'b0);
        chk("wrap_pulse_lo", int'(wrap_pulse), 0);

        // Error injection: 2 then 1,3 breaks the sequence.
        step(1'b1, 2, 1'b0);
        step(1'b1, 1, 1'b0);
        chk("err_pulse", int'(seq_err), 1);
        chk("err_state", int'(state), 1);
        chk("err_count_1", int'(err_count), 1);
        step(1'b1, 3, 1'b0);
        chk("err_no_repeat", int'(seq_err), 0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        chk("relock", int'(locked), 1);

        // Held value is one error; holds while acquiring add none.
        step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b0);
        chk("hold_err", int'(seq_err), 1);
        step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b0);
        chk("hold_err_count", int'(err_count), 2);
        step(1'b1, 3, 1'b0);
        step(1'b1, 0, 1'b0);
        chk("acq_wrap_uncounted", int'(wrap_count), 1);

        // Three more errors: five total saturates the 2-bit counter at 3.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, m_prev, 1'b0);
            relock();
        end
        chk("err_saturated", int'(err_count), 3);

        // Clear on the same edge as a wrap.
        for (int i = 0; i < 4 && m_prev != 3; i++) step(1'b1, nxt(), 1'b0);
        step(1'b1, 0, 1'b1);
        chk("clr_wrap_pulse", int'(wrap_pulse), 1);
        chk("clr_wrap_count", int'(wrap_count), 0);
        chk("clr_err_count", int'(err_count), 0);

        // Enable gating with arbitrary input while disabled.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, int'($urandom_range(0, 3)), 1'b0);
            chk("gate_pulses", int'({wrap_pulse, seq_err}), 0);
            chk("gate_state", int'(state), 2);
        end
        step(1'b1, 1, 1'b0);
        chk("gate_resume_err", int'(seq_err), 0);
        chk("gate_resume_lock", int'(locked), 1);

        // Five wraps, then async reset mid-cycle.
        repeat (20) step(1'b1, nxt(), 1'b0);
        chk("five_wraps", int'(wrap_count), 5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", int'({locked, wrap_pulse, seq_err, state}), 0);
        chk("async_rst_wrap", int'(wrap_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b1, 2, 1'b0);
        chk("post_rst_state", int'(state), 1);
        chk("post_rst_locked", int'(locked), 0);

        // Randomized: mostly-correct stream with glitches, gaps and clears.
        for (int i = 0; i < 3000; i++) begin
            int c;
            c = ($urandom_range(0, 9) < 8) ? nxt() : int'($urandom_range(0, 3));
            step($urandom_range(0, 7) != 0, c, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
